// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the decode / ID-EX / forwarding slice of the pipeline:
// field widths, ALU operation encodings, the link-register constant, the EX
// pipeline register layout and small helper functions used by several blocks.
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int DATA_W      = 32;
    localparam int ALUOP_W     = 4;
    localparam int STALL_CNT_W = 16;

    // Destination of jump-and-link style instructions.
    localparam logic [REG_ADDR_W-1:0] LINK_REG = 5'd31;
    // Hard-wired zero register: writes to it are discarded.
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

    // ALU operation encodings shared with decode and the EX ALU.
    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11,
        ALU_ADDU = 4'd12,
        ALU_SUBU = 4'd13,
        ALU_PASS = 4'd14,
        ALU_NOP  = 4'd15
    } aluop_e;

    // Control bits carried into EX.
    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   memtoreg;
        logic   alusrc;
        logic   jback;
        aluop_e aluop;
    } ex_ctrl_t;

    // Complete ID/EX pipeline register contents.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] wbadd;
        logic [DATA_W-1:0]     rdata1;
        logic [DATA_W-1:0]     rdata2;
        logic [DATA_W-1:0]     imm;
        ex_ctrl_t              ctrl;
    } ex_reg_t;

    // A bubble is the all-zero register image.
    localparam ex_reg_t EX_BUBBLE = '0;

    // Destination register selection: link beats rd beats rt.
    function automatic logic [REG_ADDR_W-1:0] resolve_wbadd(
        input logic                  jback,
        input logic                  regdst,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rt
    );
        logic [REG_ADDR_W-1:0] wb;
        if (jback) begin
            wb = LINK_REG;
        end else if (regdst) begin
            wb = rd;
        end else begin
            wb = rt;
        end
        return wb;
    endfunction

    // Saturating increment for the stall statistics counter.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(
        input logic [STALL_CNT_W-1:0] value
    );
        logic [STALL_CNT_W-1:0] res;
        if (value == STALL_CNT_MAX) begin
            res = value;
        end else begin
            res = value + 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard detector. Raises stall_o when the load
// currently in EX writes a register that the instruction in ID reads.
//
// Ports
//   rst_i          synchronous reset (stall is suppressed while asserted)
//   flush_i        redirect; kills ID, so no stall is needed
//   id_valid_i     ID holds a valid instruction
//   id_rs_i        ID source register 1
//   id_rt_i        ID source register 2
//   id_use_rt_i    ID instruction actually reads rt
//   ex_valid_i     EX holds a valid instruction
//   ex_memread_i   EX instruction is a load
//   ex_wbadd_i     EX destination register
//   stall_o        hold PC and IF/ID, insert a bubble into EX
// -----------------------------------------------------------------------------
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_use_rt_i,
    input  logic                  ex_valid_i,
    input  logic                  ex_memread_i,
    input  logic [REG_ADDR_W-1:0] ex_wbadd_i,
    output logic                  stall_o
);

    logic ex_is_load_s;
    logic rs_match_s;
    logic rt_match_s;

    // A load targeting $0 never produces a value anyone must wait for.
    assign ex_is_load_s = ex_valid_i & ex_memread_i & (ex_wbadd_i != ZERO_REG);
    assign rs_match_s   = (ex_wbadd_i == id_rs_i);
    assign rt_match_s   = id_use_rt_i & (ex_wbadd_i == id_rt_i);

    // Flush and reset both discard the ID instruction, so they mask the hazard.
    assign stall_o = id_valid_i & ex_is_load_s & (rs_match_s | rt_match_s)
                     & ~flush_i & ~rst_i;

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID->EX pipeline register with load-use interlock. Each clock the EX register
// takes either the ID instruction (destination register resolved beforehand)
// or a bubble. A bubble is inserted on flush, on load-use stall and when ID is
// empty. A saturating counter records the number of stall cycles.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   id_valid                     ID holds a valid instruction
//   id_rs/id_rt/id_rd            decoded register fields
//   id_rdata1/id_rdata2/id_imm   operands
//   id_regwrite..id_use_rt       decoded control bits
//   id_aluop                     ALU operation
//   flush                        redirect, kill the ID instruction
//   ex_*                         registered EX-stage contents
//   stall                        combinational load-use stall request
//   stall_cnt                    saturating count of stall cycles
// -----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rdata1,
    input  logic [31:0] id_rdata2,
    input  logic [31:0] id_imm,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        id_memtoreg,
    input  logic        id_alusrc,
    input  logic        id_regdst,
    input  logic        id_jback,
    input  logic        id_use_rt,
    input  logic [3:0]  id_aluop,
    input  logic        flush,
    output logic        ex_valid,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_wbadd,
    output logic [31:0] ex_rdata1,
    output logic [31:0] ex_rdata2,
    output logic [31:0] ex_imm,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_memtoreg,
    output logic        ex_alusrc,
    output logic        ex_jback,
    output logic [3:0]  ex_aluop,
    output logic        stall,
    output logic [15:0] stall_cnt
);

    ex_reg_t                  ex_q;
    ex_reg_t                  ex_d;
    logic [STALL_CNT_W-1:0]   stall_cnt_q;
    logic [STALL_CNT_W-1:0]   stall_cnt_d;
    logic                     stall_s;
    logic                     load_s;
    logic [REG_ADDR_W-1:0]    wbadd_s;

    load_use_detect u_load_use_detect (
        .rst_i        (rst),
        .flush_i      (flush),
        .id_valid_i   (id_valid),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_use_rt_i  (id_use_rt),
        .ex_valid_i   (ex_q.valid),
        .ex_memread_i (ex_q.ctrl.memread),
        .ex_wbadd_i   (ex_q.wbadd),
        .stall_o      (stall_s)
    );

    assign wbadd_s = resolve_wbadd(id_jback, id_regdst, id_rd, id_rt);

    // The ID instruction advances only when valid, not killed and not stalled.
    assign load_s = id_valid & ~flush & ~stall_s;

    // Next EX register image: the ID instruction or a bubble.
    always_comb begin
        ex_d = EX_BUBBLE;
        if (load_s) begin
            ex_d.valid         = 1'b1;
            ex_d.rs            = id_rs;
            ex_d.rt            = id_rt;
            ex_d.wbadd         = wbadd_s;
            ex_d.rdata1        = id_rdata1;
            ex_d.rdata2        = id_rdata2;
            ex_d.imm           = id_imm;
            // A write to $0 is dropped here so later stages never see it.
            ex_d.ctrl.regwrite = id_regwrite & (wbadd_s != ZERO_REG);
            ex_d.ctrl.memread  = id_memread;
            ex_d.ctrl.memwrite = id_memwrite;
            ex_d.ctrl.memtoreg = id_memtoreg;
            ex_d.ctrl.alusrc   = id_alusrc;
            ex_d.ctrl.jback    = id_jback;
            ex_d.ctrl.aluop    = aluop_e'(id_aluop);
        end else begin
            ex_d = EX_BUBBLE;
        end
    end

    // Next stall counter value: count every stall cycle, never wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // EX pipeline register and stall counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= EX_BUBBLE;
            stall_cnt_q <= 16'd0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_rs       = ex_q.rs;
    assign ex_rt       = ex_q.rt;
    assign ex_wbadd    = ex_q.wbadd;
    assign ex_rdata1   = ex_q.rdata1;
    assign ex_rdata2   = ex_q.rdata2;
    assign ex_imm      = ex_q.imm;
    assign ex_regwrite = ex_q.ctrl.regwrite;
    assign ex_memread  = ex_q.ctrl.memread;
    assign ex_memwrite = ex_q.ctrl.memwrite;
    assign ex_memtoreg = ex_q.ctrl.memtoreg;
    assign ex_alusrc   = ex_q.ctrl.alusrc;
    assign ex_jback    = ex_q.ctrl.jback;
    assign ex_aluop    = ex_q.ctrl.aluop;
    assign stall       = stall_s;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Table-driven bench for id_ex_stage. Each table row is one clock of ID input
// plus hand-derived stall / advance / counter expectations; expected EX
// contents are built from the row and queued, then compared after the edge.
// Hand-written sequences cover counter saturation and reset during a hazard.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    // Control byte order: {regwrite, memread, memwrite, memtoreg, alusrc,
    //                      regdst, jback, use_rt}
    localparam logic [7:0] C_LW   = 8'b1101_1000;
    localparam logic [7:0] C_ADD  = 8'b1000_0101;
    localparam logic [7:0] C_SW   = 8'b0010_1001;
    localparam logic [7:0] C_SWNR = 8'b0010_1000;
    localparam logic [7:0] C_JAL  = 8'b1000_0010;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
        logic        exp_stall;
        logic        exp_load;
        logic [15:0] exp_cnt;
    } vec_t;

    typedef struct {
        int           idx;
        logic [121:0] bundle;
        logic [15:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        id_alusrc, id_regdst, id_jback, id_use_rt;
    logic [3:0]  id_aluop;
    logic        flush;
    logic        ex_valid;
    logic [4:0]  ex_rs, ex_rt, ex_wbadd;
    logic [31:0] ex_rdata1, ex_rdata2, ex_imm;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic        ex_alusrc, ex_jback;
    logic [3:0]  ex_aluop;
    logic        stall;
    logic [15:0] stall_cnt;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_jback(id_jback),
        .id_use_rt(id_use_rt), .id_aluop(id_aluop), .flush(flush),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wbadd(ex_wbadd),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_alusrc(ex_alusrc), .ex_jback(ex_jback), .ex_aluop(ex_aluop),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    function automatic vec_t mkv(input logic r, input logic f, input logic v,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [7:0] c,
                                 input logic es, input logic el,
                                 input logic [15:0] ec);
        vec_t x;
        x.rst = r; x.flush = f; x.valid = v; x.rs = rs; x.rt = rt; x.rd = rd;
        x.ctrl = c; x.exp_stall = es; x.exp_load = el; x.exp_cnt = ec;
        return x;
    endfunction

    // Reference EX contents for a row: bubble, or ID fields with the
    // destination chosen link > rd > rt and $0 writes suppressed.
    function automatic logic [121:0] model_ex(input vec_t x, input int i);
        logic [4:0] wb;
        logic       rw;
        if (!x.exp_load) begin
            return 122'd0;
        end
        if (x.ctrl[1]) wb = 5'd31;
        else if (x.ctrl[2]) wb = x.rd;
        else wb = x.rt;
        rw = x.ctrl[7] && (wb != 5'd0);
        return {1'b1, x.rs, x.rt, wb, 32'h1111_0000 + 32'(i),
                32'h2222_0000 + 32'(i), 32'h3333_0000 + 32'(i), rw,
                x.ctrl[6], x.ctrl[5], x.ctrl[4], x.ctrl[3], x.ctrl[1], 4'(i)};
    endfunction

    task automatic drive(input vec_t x, input int i);
        rst = x.rst; flush = x.flush; id_valid = x.valid;
        id_rs = x.rs; id_rt = x.rt; id_rd = x.rd;
        {id_regwrite, id_memread, id_memwrite, id_memtoreg,
         id_alusrc, id_regdst, id_jback, id_use_rt} = x.ctrl;
        id_rdata1 = 32'h1111_0000 + 32'(i);
        id_rdata2 = 32'h2222_0000 + 32'(i);
        id_imm    = 32'h3333_0000 + 32'(i);
        id_aluop  = 4'(i);
    endtask

    task automatic check1(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        logic [121:0] act;
        vec_t hv;
        // rst flush valid rs rt rd ctrl stall load cnt
        vecs.push_back(mkv(1'b1,1'b0,1'b1,5'd1, 5'd8, 5'd0, C_LW,  1'b0,1'b0,16'd0)); // 0 reset
        vecs.push_back(mkv(1'b1,1'b0,1'b1,5'd8, 5'd8, 5'd0, C_ADD, 1'b0,1'b0,16'd0)); // 1 reset
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd1, 5'd8, 5'd0, C_LW,  1'b0,1'b1,16'd0)); // 2 lw $8
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd8, 5'd2, 5'd3, C_ADD, 1'b1,1'b0,16'd1)); // 3 rs hazard
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd8, 5'd2, 5'd3, C_ADD, 1'b0,1'b1,16'd1)); // 4 retry
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd3, 5'd9, 5'd0, C_LW,  1'b0,1'b1,16'd1)); // 5 non-load prod
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd4, 5'd9, 5'd0, C_SW,  1'b1,1'b0,16'd2)); // 6 rt hazard
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd4, 5'd9, 5'd0, C_SW,  1'b0,1'b1,16'd2)); // 7
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd0, 5'd9, 5'd0, C_LW,  1'b0,1'b1,16'd2)); // 8 lw $9
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd5, 5'd9, 5'd0, C_SWNR,1'b0,1'b1,16'd2)); // 9 rt unused
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd1, 5'd0, 5'd0, C_LW,  1'b0,1'b1,16'd2)); // 10 lw $0
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd0, 5'd0, 5'd0, C_ADD, 1'b0,1'b1,16'd2)); // 11 addu $0
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd0, 5'd0, 5'd5, C_JAL, 1'b0,1'b1,16'd2)); // 12 jal
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd1, 5'd10,5'd0, C_LW,  1'b0,1'b1,16'd2)); // 13 lw $10
        vecs.push_back(mkv(1'b0,1'b1,1'b1,5'd10,5'd2, 5'd11,C_ADD, 1'b0,1'b0,16'd2)); // 14 flush
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd10,5'd2, 5'd11,C_ADD, 1'b0,1'b1,16'd2)); // 15
        vecs.push_back(mkv(1'b0,1'b0,1'b0,5'd1, 5'd12,5'd0, C_LW,  1'b0,1'b0,16'd2)); // 16 idle
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd1, 5'd12,5'd0, C_LW,  1'b0,1'b1,16'd2)); // 17
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd12,5'd13,5'd0, C_LW,  1'b1,1'b0,16'd3)); // 18 b2b 1
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd12,5'd13,5'd0, C_LW,  1'b0,1'b1,16'd3)); // 19
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd13,5'd2, 5'd14,C_ADD, 1'b1,1'b0,16'd4)); // 20 b2b 2
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd13,5'd2, 5'd14,C_ADD, 1'b0,1'b1,16'd4)); // 21
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd1, 5'd15,5'd0, C_LW,  1'b0,1'b1,16'd4)); // 22
        vecs.push_back(mkv(1'b1,1'b0,1'b1,5'd15,5'd2, 5'd3, C_ADD, 1'b0,1'b0,16'd0)); // 23 rst hazard
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd15,5'd2, 5'd3, C_ADD, 1'b0,1'b1,16'd0)); // 24
        vecs.push_back(mkv(1'b0,1'b0,1'b1,5'd1, 5'd16,5'd0, C_LW,  1'b0,1'b1,16'd0)); // 25
        vecs.push_back(mkv(1'b0,1'b0,1'b0,5'd16,5'd2, 5'd0, C_ADD, 1'b0,1'b0,16'd0)); // 26 id empty

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i], i);
            #1;
            check1($sformatf("stall[%0d]", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
            e.idx = i; e.bundle = model_ex(vecs[i], i); e.cnt = vecs[i].exp_cnt;
            sb.push_back(e);
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL scoreboard[%0d]: queue empty", i);
            end else begin
                e = sb.pop_front();
                act = {ex_valid, ex_rs, ex_rt, ex_wbadd, ex_rdata1, ex_rdata2, ex_imm,
                       ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
                       ex_alusrc, ex_jback, ex_aluop};
                if (act !== e.bundle) begin
                    failures++;
                    $display("FAIL ex[%0d]: got %h expected %h", e.idx, act, e.bundle);
                end
                check1($sformatf("stall_cnt[%0d]", e.idx), {16'd0, stall_cnt}, {16'd0, e.cnt});
            end
        end

        // Saturation: preload the counter near its ceiling, then stall three times.
        @(negedge clk);
        hv = mkv(1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,C_ADD,1'b0,1'b0,16'd0);
        drive(hv, 0);
        force dut.stall_cnt_d = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.stall_cnt_d;
        for (int k = 0; k < 3; k++) begin
            drive(mkv(1'b0,1'b0,1'b1,5'd1,5'd20,5'd0,C_LW,1'b0,1'b1,16'd0), 1);
            @(negedge clk);
            drive(mkv(1'b0,1'b0,1'b1,5'd20,5'd2,5'd3,C_ADD,1'b0,1'b0,16'd0), 2);
            #1;
            check1($sformatf("sat_stall[%0d]", k), {31'd0, stall}, 32'd1);
            @(posedge clk);
            #1;
            check1($sformatf("sat_cnt[%0d]", k), {16'd0, stall_cnt}, 32'h0000_FFFF);
            @(negedge clk);
        end

        // Reset arriving while a hazard is pending.
        drive(mkv(1'b0,1'b0,1'b1,5'd1,5'd20,5'd0,C_LW,1'b0,1'b1,16'd0), 3);
        @(negedge clk);
        drive(mkv(1'b1,1'b0,1'b1,5'd20,5'd2,5'd3,C_ADD,1'b0,1'b0,16'd0), 4);
        #1;
        check1("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        check1("rst_cnt", {16'd0, stall_cnt}, 32'd0);
        check1("rst_valid", {31'd0, ex_valid}, 32'd0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have these ports; single clock domain; synchronous, active-high reset.
  clk  in  1  rising-edge clock
  rst  in  1  synchronous, active-high reset
  id_valid  in  1  ID holds a valid instruction
  id_rs, id_rt, id_rd  in  5 each  decoded register fields
  id_rdata1, id_rdata2  in  32 each  register-file read data
  id_imm  in  32  extended immediate
  id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst, id_jback, id_use_rt  in  1 each  decoded controls
  id_aluop  in  4  ALU operation
  flush  in  1  branch/jump redirect, kill ID instruction
  ex_valid  out  1  EX holds a valid instruction
  ex_rs, ex_rt  out  5 each  source fields to ALU forwarding
  ex_wbadd  out  5  resolved destination register
  ex_rdata1, ex_rdata2, ex_imm  out  32 each  operands
  ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_jback  out  1 each
  ex_aluop  out  4
  stall  out  1  hold PC and IF/ID this cycle
  stall_cnt  out  16  saturating count of load-use stall cycles

Function
REQ-002 Register: on each rising clk edge not in reset, the EX register SHALL load either the ID instruction or a bubble; latency ID->EX exactly 1 cycle.
REQ-003 Bubble: ex_valid=0 and all ex_ control bits, ex_aluop, ex_wbadd SHALL be 0; data fields (rs, rt, rdata, imm) SHALL be 0.
REQ-004 wbadd: id_jback=1 -> 31; else id_regdst=1 -> id_rd; else id_rt; resolved before registering.
REQ-005 ex_regwrite SHALL be 0 when resolved wbadd=0, regardless of id_regwrite.
REQ-006 stall (combinational) SHALL be 1 iff id_valid & ex_valid & ex_memread & ex_wbadd!=0 & (ex_wbadd==id_rs | (id_use_rt & ex_wbadd==id_rt)) & !flush.
REQ-007 stall=1: EX SHALL load a bubble; ID inputs held upstream; next cycle stall re-evaluates (drops since bubble has memread=0).
REQ-008 flush=1: EX SHALL load a bubble; flush has priority over stall (stall forced 0).
REQ-009 id_valid=0 with no flush/stall: EX SHALL load a bubble.
REQ-010 stall_cnt SHALL increment by 1 each cycle stall=1, saturating at 16'hFFFF (no wrap).
REQ-011 Back-to-back load-use pairs SHALL each produce exactly one stall cycle.

Reset
REQ-012 rst=1 at a clock edge SHALL make EX a bubble and stall_cnt=0, overriding flush and stall.
REQ-013 During reset stall SHALL read 0 (ex_valid=0 after first reset edge); reset mid-stall discards the pending hazard.

Structure
REQ-014 Control field widths, aluop encodings, and register-31 link constant SHALL live in a shared package used by decode, this block and forwarding.
REQ-015 Hazard detection SHALL be a sub-module load_use_detect (combinational, stall output); register and counter in id_ex_stage.

Verification
REQ-016 Load then dependent: EX lw wbadd=8 memread=1; ID add rs=8 -> stall=1 one cycle, EX bubble, stall_cnt 0->1, then add enters EX.
REQ-017 rt-only hazard: EX lw wbadd=9; ID sw rt=9 id_use_rt=1 -> stall=1; same with id_use_rt=0 -> stall=0.
REQ-018 $0 target: EX lw wbadd=0; ID rs=0 -> stall=0; ID addu regdst=1 rd=0 regwrite=1 -> ex_regwrite=0.
REQ-019 jal: id_jback=1, id_rd=5 -> ex_wbadd=31, ex_jback=1 next cycle.
REQ-020 flush during hazard: stall conditions true and flush=1 -> stall=0, EX bubble, stall_cnt unchanged.
REQ-021 Counter/reset: force stall_cnt to FFFF via 65535 stall cycles -> stays FFFF on further stall; rst=1 -> 0, ex_valid=0.
